mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 65 ++++++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of fetch port, data port and shared memory command
//               signals around the instruction/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int c_MASK_WIDTH = DATA_WIDTH / 8;

    // Instruction-fetch port
    logic                    i_req_valid;
    logic [ADDR_WIDTH-1:0]   i_req_addr;
    logic                    i_req_ready;
    logic                    i_rsp_valid;
    logic [DATA_WIDTH-1:0]   i_rsp_data;

    // Load/store port
    logic                    d_req_valid;
    logic                    d_req_we;
    logic [ADDR_WIDTH-1:0]   d_req_addr;
    logic [DATA_WIDTH-1:0]   d_req_wdata;
    logic [c_MASK_WIDTH-1:0] d_req_mask;
    logic                    d_req_ready;
    logic                    d_rsp_valid;
    logic [DATA_WIDTH-1:0]   d_rsp_data;

    // Shared single-port memory
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [c_MASK_WIDTH-1:0] mem_mask;
    logic                    mem_gnt;
    logic                    mem_rvalid;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    logic                    busy;

    // Arbiter side
    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_data,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_mask,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output busy
    );

    // Requester / memory environment side
    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_data,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_mask,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one single-port memory between an
//               instruction-fetch port and a load/store port, one transaction
//               outstanding at a time (IDLE -> ISSUE -> WAIT -> RESP).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);
    localparam int c_MASK_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic                    r_last_d;    // 1 = data port won the last grant
    logic                    r_owner_d;   // 1 = data port owns the transaction
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_MASK_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0]   r_i_rsp_data;
    logic [DATA_WIDTH-1:0]   r_d_rsp_data;
    logic                    w_grant_i;
    logic                    w_grant_d;

    // Round-robin grant, only offered in IDLE and never while reset is high
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == c_IDLE && !rst) begin
            if (bus.i_req_valid && bus.d_req_valid) begin
                w_grant_i = r_last_d;
                w_grant_d = !r_last_d;
            end else begin
                w_grant_i = bus.i_req_valid;
                w_grant_d = bus.d_req_valid;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; gnt and rvalid are only looked at in their own state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_grant_i || w_grant_d) w_next_state = c_ISSUE;
            c_ISSUE: if (bus.mem_gnt)            w_next_state = c_WAIT;
            c_WAIT:  if (bus.mem_rvalid)         w_next_state = c_RESP;
            c_RESP:                              w_next_state = c_IDLE;
            default:                             w_next_state = c_IDLE;
        endcase
    end

    // Command latch on grant and response capture on memory completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d     <= 1'b1;
            r_owner_d    <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mask       <= '0;
            r_i_rsp_data <= '0;
            r_d_rsp_data <= '0;
        end else begin
            if (w_grant_i) begin
                r_last_d  <= 1'b0;
                r_owner_d <= 1'b0;
                r_we      <= 1'b0;
                r_addr    <= bus.i_req_addr;
                r_wdata   <= '0;
                r_mask    <= '0;
            end else if (w_grant_d) begin
                r_last_d  <= 1'b1;
                r_owner_d <= 1'b1;
                r_we      <= bus.d_req_we;
                r_addr    <= bus.d_req_addr;
                r_wdata   <= bus.d_req_wdata;
                r_mask    <= bus.d_req_mask;
            end
            if (r_state == c_WAIT && bus.mem_rvalid) begin
                if (r_owner_d) begin
                    r_d_rsp_data <= r_we ? '0 : bus.mem_rdata;
                end else begin
                    r_i_rsp_data <= bus.mem_rdata;
                end
            end
        end
    end

    // Output decode: readies in IDLE, command in ISSUE, pulse in RESP
    always_comb begin
        bus.i_req_ready = w_grant_i;
        bus.d_req_ready = w_grant_d;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.mem_mask    = '0;
        bus.i_rsp_valid = 1'b0;
        bus.d_rsp_valid = 1'b0;
        bus.i_rsp_data  = r_i_rsp_data;
        bus.d_rsp_data  = r_d_rsp_data;
        bus.busy        = (r_state != c_IDLE);
        if (r_state == c_ISSUE) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = r_we;
            bus.mem_addr  = r_addr;
            bus.mem_wdata = r_wdata;
            bus.mem_mask  = r_mask;
        end
        if (r_state == c_RESP) begin
            bus.i_rsp_valid = !r_owner_d;
            bus.d_rsp_valid = r_owner_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic clear_inputs();
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = '0;
        bus.d_req_valid = 1'b0;
        bus.d_req_we    = 1'b0;
        bus.d_req_addr  = '0;
        bus.d_req_wdata = '0;
        bus.d_req_mask  = '0;
        bus.mem_gnt     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({bus.busy, bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid, bus.d_rsp_valid, bus.mem_req} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {bus.busy, bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid, bus.d_rsp_valid, bus.mem_req});
        end
        n_tests++;
        if ({bus.i_rsp_data, bus.d_rsp_data, bus.mem_addr, bus.mem_wdata, bus.mem_mask, bus.mem_we} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: i_rsp_data=%h d_rsp_data=%h mem_addr=%h required all 0",
                     bus.i_rsp_data, bus.d_rsp_data, bus.mem_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h8000_0000;
        #1;
        n_tests++;
        if ({bus.i_req_ready, bus.d_req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL fetch_ready: got %b required 10", {bus.i_req_ready, bus.d_req_ready});
        end
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        bus.mem_gnt     = 1'b1;
        #1;
        n_tests++;
        if ({bus.mem_req, bus.mem_we, bus.mem_mask, bus.mem_wdata, bus.mem_addr, bus.busy} !==
            {1'b1, 1'b0, 4'h0, 32'h0, 32'h8000_0000, 1'b1}) begin
            n_fail++;
            $display("FAIL fetch_cmd: req=%b we=%b mask=%h wdata=%h addr=%h busy=%b required 1 0 0 0 80000000 1",
                     bus.mem_req, bus.mem_we, bus.mem_mask, bus.mem_wdata, bus.mem_addr, bus.busy);
        end
        @(negedge clk);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0013;
        #1;
        n_tests++;
        if ({bus.mem_req, bus.i_rsp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_wait: mem_req/i_rsp_valid got %b required 00", {bus.mem_req, bus.i_rsp_valid});
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        n_tests++;
        if ({bus.i_rsp_valid, bus.d_rsp_valid, bus.i_rsp_data} !== {1'b1, 1'b0, 32'h0000_0013}) begin
            n_fail++;
            $display("FAIL fetch_rsp: i_valid=%b d_valid=%b data=%h required 1 0 00000013",
                     bus.i_rsp_valid, bus.d_rsp_valid, bus.i_rsp_data);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({bus.i_rsp_valid, bus.busy, bus.i_rsp_data} !== {1'b0, 1'b0, 32'h0000_0013}) begin
            n_fail++;
            $display("FAIL fetch_after: i_valid=%b busy=%b data=%h required 0 0 00000013",
                     bus.i_rsp_valid, bus.busy, bus.i_rsp_data);
        end
    endtask

    task automatic test_store();
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 1'b1;
        bus.d_req_addr  = 32'h0000_0100;
        bus.d_req_wdata = 32'hDEAD_BEEF;
        bus.d_req_mask  = 4'b0011;
        #1;
        n_tests++;
        if ({bus.i_req_ready, bus.d_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL store_ready: got %b required 01", {bus.i_req_ready, bus.d_req_ready});
        end
        @(negedge clk);
        clear_inputs();
        for (int s = 0; s < 3; s++) begin
            #1;
            n_tests++;
            if ({bus.mem_req, bus.mem_we, bus.mem_mask, bus.mem_addr, bus.mem_wdata} !==
                {1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF}) begin
                n_fail++;
                $display("FAIL store_stall%0d: req=%b we=%b mask=%b addr=%h wdata=%h required 1 1 0011 00000100 deadbeef",
                         s, bus.mem_req, bus.mem_we, bus.mem_mask, bus.mem_addr, bus.mem_wdata);
            end
            @(negedge clk);
        end
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        n_tests++;
        if ({bus.d_rsp_valid, bus.i_rsp_valid, bus.d_rsp_data} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL store_rsp: d_valid=%b i_valid=%b d_data=%h required 1 0 00000000",
                     bus.d_rsp_valid, bus.i_rsp_valid, bus.d_rsp_data);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({bus.d_rsp_valid, bus.busy, bus.i_rsp_data} !== {1'b0, 1'b0, 32'h0000_0013}) begin
            n_fail++;
            $display("FAIL store_once: d_valid=%b busy=%b i_data=%h required 0 0 00000013",
                     bus.d_rsp_valid, bus.busy, bus.i_rsp_data);
        end
    endtask

    task automatic test_contention();
        logic        exp_d;
        logic [31:0] exp_data;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h0000_1000;
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 1'b0;
        bus.d_req_addr  = 32'h0000_2000;
        for (int k = 0; k < 4; k++) begin
            exp_d    = (k % 2) == 1;
            exp_data = 32'hA0 + k;
            #1;
            n_tests++;
            if ({bus.i_req_ready, bus.d_req_ready} !== {!exp_d, exp_d}) begin
                n_fail++;
                $display("FAIL contention_grant%0d: ready i/d got %b required %b",
                         k, {bus.i_req_ready, bus.d_req_ready}, {!exp_d, exp_d});
            end
            @(negedge clk);
            bus.mem_gnt = 1'b1;
            #1;
            n_tests++;
            if ({bus.i_req_ready, bus.d_req_ready, bus.mem_addr} !==
                {2'b00, (exp_d ? 32'h0000_2000 : 32'h0000_1000)}) begin
                n_fail++;
                $display("FAIL contention_issue%0d: readies=%b addr=%h", k,
                         {bus.i_req_ready, bus.d_req_ready}, bus.mem_addr);
            end
            @(negedge clk);
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = exp_data;
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            #1;
            n_tests++;
            if ({bus.i_rsp_valid, bus.d_rsp_valid, (exp_d ? bus.d_rsp_data : bus.i_rsp_data)} !==
                {!exp_d, exp_d, exp_data}) begin
                n_fail++;
                $display("FAIL contention_rsp%0d: i_valid=%b d_valid=%b i_data=%h d_data=%h required port_d=%b data=%h",
                         k, bus.i_rsp_valid, bus.d_rsp_valid, bus.i_rsp_data, bus.d_rsp_data, exp_d, exp_data);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_stray_rvalid();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0077;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        n_tests++;
        if ({bus.busy, bus.i_rsp_valid, bus.d_rsp_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL stray_idle: busy/i_valid/d_valid got %b required 000",
                     {bus.busy, bus.i_rsp_valid, bus.d_rsp_valid});
        end
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h0000_3000;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        bus.mem_rvalid  = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        n_tests++;
        if ({bus.mem_req, bus.i_rsp_valid, bus.d_rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL stray_issue: mem_req/i_valid/d_valid got %b required 100",
                     {bus.mem_req, bus.i_rsp_valid, bus.d_rsp_valid});
        end
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0099;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        n_tests++;
        if ({bus.i_rsp_valid, bus.i_rsp_data} !== {1'b1, 32'h0000_0099}) begin
            n_fail++;
            $display("FAIL stray_complete: i_valid=%b i_data=%h required 1 00000099",
                     bus.i_rsp_valid, bus.i_rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h0000_4000;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        bus.mem_gnt     = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0055;
        #1;
        n_tests++;
        if ({bus.busy, bus.i_rsp_valid, bus.d_rsp_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL resetmid_state: busy/i_valid/d_valid got %b required 000",
                     {bus.busy, bus.i_rsp_valid, bus.d_rsp_valid});
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        n_tests++;
        if ({bus.busy, bus.i_rsp_valid, bus.d_rsp_valid, bus.i_rsp_data} !== {3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL resetmid_ignore: busy=%b i_valid=%b d_valid=%b i_data=%h required 0 0 0 00000000",
                     bus.busy, bus.i_rsp_valid, bus.d_rsp_valid, bus.i_rsp_data);
        end
        bus.i_req_valid = 1'b1;
        bus.d_req_valid = 1'b1;
        #1;
        n_tests++;
        if ({bus.i_req_ready, bus.d_req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL resetmid_tie: ready i/d got %b required 10", {bus.i_req_ready, bus.d_req_ready});
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_stray_rvalid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
